// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared FSM states, BCD digit limits and field layout for the stopwatch
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSED,
      ST_DONE
   } state_t;

   localparam logic [3:0] ONES_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'd5;

   localparam int DIGIT_W  = 4;
   localparam int DIGITS   = 4;
   localparam int SEC_ONES = 0;
   localparam int SEC_TENS = 1;
   localparam int MIN_ONES = 2;
   localparam int MIN_TENS = 3;

   function automatic logic [3:0] digit_limit(input int idx);
      case (idx)
         SEC_ONES, MIN_ONES: return ONES_MAX;
         SEC_TENS, MIN_TENS: return TENS_MAX;
         default:            return ONES_MAX;
      endcase
   endfunction

   // Out-of-range preset digits saturate at their limit rather than wrapping.
   function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*DIGIT_W +: DIGIT_W] = (v[i*DIGIT_W +: DIGIT_W] > digit_limit(i)) ?
                                   digit_limit(i) : v[i*DIGIT_W +: DIGIT_W];
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// rtl/bcd_digit_updown.sv - one BCD digit stepped up or down, wrapping at 0/limit with carry/borrow out
module bcd_digit_updown (
   input  logic [3:0] digit,
   input  logic       en,
   input  logic       dir,
   input  logic [3:0] limit,
   output logic [3:0] digit_nxt,
   output logic       carry
);

   always_comb begin
      digit_nxt = digit;
      carry     = 1'b0;
      if (en) begin
         if (!dir) begin
            if (digit >= limit) begin
               digit_nxt = 4'd0;
               carry     = 1'b1;
            end else begin
               digit_nxt = digit + 4'd1;
            end
         end else begin
            if (digit == 4'd0) begin
               digit_nxt = limit;
               carry     = 1'b1;
            end else begin
               digit_nxt = digit - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/stopwatch_timer.sv
// rtl/stopwatch_timer.sv - mm:ss BCD stopwatch / countdown timer with lap capture
module stopwatch_timer
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter bit LAP_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pause,
   input  logic        clear,
   input  logic        mode_down,
   input  logic        load,
   input  logic [15:0] preset,
   input  logic        lap,
   output logic [15:0] time_bcd,
   output logic [15:0] lap_bcd,
   output logic        lap_valid,
   output logic        running,
   output logic        done
);

   localparam int            PW        = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

   state_t          state, state_nxt;
   logic [PW-1:0]   presc;
   logic            dir_down;
   logic            tick;
   logic            load_ok;
   logic [15:0]     time_tick;
   logic [DIGITS:0] en;
   logic            unused_wrap;

   // A pause arriving in the tick cycle wins: the prescaler freezes and no tick is taken.
   assign tick    = (state == ST_RUN) && !pause && (presc == PRESC_MAX);
   assign load_ok = load && (state == ST_IDLE || state == ST_DONE);

   assign en[0] = tick;
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_updown u_digit (
         .digit     (time_bcd[i*DIGIT_W +: DIGIT_W]),
         .en        (en[i]),
         .dir       (dir_down),
         .limit     (digit_limit(i)),
         .digit_nxt (time_tick[i*DIGIT_W +: DIGIT_W]),
         .carry     (en[i+1])
      );
   end
   assign unused_wrap = en[DIGITS];

   always_comb begin
      state_nxt = state;
      if (clear || load_ok) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (start && !pause)
                          state_nxt = (mode_down && time_bcd == 16'h0000) ? ST_DONE : ST_RUN;
            ST_RUN:    if (pause)
                          state_nxt = ST_PAUSED;
                       else if (tick && dir_down && time_tick == 16'h0000)
                          state_nxt = ST_DONE;
            ST_PAUSED: if (start && !pause)
                          state_nxt = ST_RUN;
            default:   state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         presc     <= '0;
         dir_down  <= 1'b0;
         time_bcd  <= 16'h0000;
         lap_bcd   <= 16'h0000;
         lap_valid <= 1'b0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         running   <= (state_nxt == ST_RUN);
         done      <= (state_nxt == ST_DONE);
         lap_valid <= 1'b0;
         if (clear) begin
            time_bcd <= 16'h0000;
            lap_bcd  <= 16'h0000;
            presc    <= '0;
         end else if (load_ok) begin
            time_bcd <= clamp_bcd(preset);
         end else begin
            if (state == ST_IDLE && state_nxt != ST_IDLE) begin
               presc    <= '0;
               dir_down <= mode_down;
            end else if (state == ST_RUN && !pause) begin
               presc <= tick ? '0 : presc + 1'b1;
               if (tick)
                  time_bcd <= time_tick;
            end
            // Capture uses the pre-tick count even when a tick lands on the same edge.
            if (LAP_EN && lap && (state == ST_RUN || state == ST_PAUSED)) begin
               lap_bcd   <= time_bcd;
               lap_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb/tb_stopwatch_timer.sv - scoreboard bench for stopwatch_timer at CLK_HZ=4
module tb_stopwatch_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, pause, clear, mode_down, load, lap;
   logic [15:0] preset;
   logic [15:0] time_bcd, lap_bcd;
   logic        lap_valid, running, done;

   stopwatch_timer #(.CLK_HZ(4), .LAP_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pause     (pause),
      .clear     (clear),
      .mode_down (mode_down),
      .load      (load),
      .preset    (preset),
      .lap       (lap),
      .time_bcd  (time_bcd),
      .lap_bcd   (lap_bcd),
      .lap_valid (lap_valid),
      .running   (running),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      string       tag;
      logic [15:0] tm;
      logic        rn;
      logic        dn;
      logic [15:0] lp;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] lap_q[$];
   int          cyc     = 0;
   int          n_tests = 0;
   int          n_fail  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push_at(input string tag, input int due, input logic [15:0] tm,
                          input logic rn, input logic dn, input logic [15:0] lp);
      sb_q.push_back('{due: due, tag: tag, tm: tm, rn: rn, dn: dn, lp: lp});
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         exp_t e;
         e = sb_q.pop_front();
         check_eq($sformatf("%s_time", e.tag), time_bcd, e.tm);
         check_eq($sformatf("%s_run", e.tag), {15'd0, running}, {15'd0, e.rn});
         check_eq($sformatf("%s_done", e.tag), {15'd0, done}, {15'd0, e.dn});
         check_eq($sformatf("%s_lap", e.tag), lap_bcd, e.lp);
      end
   end

   always @(negedge clk) begin
      if (lap_valid) begin
         if (lap_q.size() == 0)
            check_eq("lap_spurious", {15'd0, lap_valid}, 16'h0000);
         else
            check_eq("lap_capture", lap_bcd, lap_q.pop_front());
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int k = 0;
      while ((sb_q.size() != 0 || lap_q.size() != 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (sb_q.size() != 0 || lap_q.size() != 0) begin
         check_eq("drain_timeout", 16'(sb_q.size() + lap_q.size()), 16'h0000);
         sb_q.delete();
         lap_q.delete();
      end
   endtask

   task automatic do_load(input logic [15:0] p);
      load = 1'b1; preset = p;
      tick_n(1);
      load = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick_n(1);
      clear = 1'b0;
   endtask

   task automatic start_run(input logic down, output int t0);
      start = 1'b1; mode_down = down; t0 = cyc;
      tick_n(1);
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int t0;
      rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
      mode_down = 1'b0; load = 1'b0; lap = 1'b0; preset = 16'h0000;

      tick_n(2);
      check_eq("rst_time", time_bcd, 16'h0000);
      check_eq("rst_lap", lap_bcd, 16'h0000);
      check_eq("rst_lapv", {15'd0, lap_valid}, 16'h0000);
      check_eq("rst_run", {15'd0, running}, 16'h0000);
      check_eq("rst_done", {15'd0, done}, 16'h0000);

      // start honoured on the first edge after release
      rst = 1'b0; start = 1'b1;
      push_at("rel", cyc + 1, 16'h0000, 1'b1, 1'b0, 16'h0000);
      tick_n(1);
      start = 1'b0;
      drain();
      push_at("clr", cyc + 1, 16'h0000, 1'b0, 1'b0, 16'h0000);
      do_clear();
      drain();

      // up-count wrap 59:59 -> 00:00
      do_load(16'h5958);
      start_run(1'b0, t0);
      push_at("upw_a", t0 + 4, 16'h5958, 1'b1, 1'b0, 16'h0000);
      push_at("upw_b", t0 + 5, 16'h5959, 1'b1, 1'b0, 16'h0000);
      push_at("upw_c", t0 + 9, 16'h0000, 1'b1, 1'b0, 16'h0000);
      drain();

      // countdown to done, start ignored afterwards
      do_clear();
      do_load(16'h0002);
      start_run(1'b1, t0);
      push_at("cd_a", t0 + 5, 16'h0001, 1'b1, 1'b0, 16'h0000);
      push_at("cd_b", t0 + 9, 16'h0000, 1'b0, 1'b1, 16'h0000);
      drain();
      start = 1'b1;
      tick_n(3);
      start = 1'b0;
      push_at("cd_ign", cyc + 1, 16'h0000, 1'b0, 1'b1, 16'h0000);
      drain();

      // down start at 00:00 goes straight to done
      do_clear();
      start_run(1'b1, t0);
      push_at("dz_a", t0 + 1, 16'h0000, 1'b0, 1'b1, 16'h0000);
      push_at("dz_b", t0 + 6, 16'h0000, 1'b0, 1'b1, 16'h0000);
      drain();

      // pause at prescaler 2 in down mode; direction must survive a mode_down change
      do_clear();
      do_load(16'h0003);
      start_run(1'b1, t0);
      tick_n(2);
      pause = 1'b1;
      push_at("pz_mid", t0 + 8, 16'h0003, 1'b0, 1'b0, 16'h0000);
      push_at("pz_end", t0 + 13, 16'h0003, 1'b0, 1'b0, 16'h0000);
      push_at("pz_res", t0 + 14, 16'h0003, 1'b1, 1'b0, 16'h0000);
      push_at("pz_pre", t0 + 15, 16'h0003, 1'b1, 1'b0, 16'h0000);
      push_at("pz_tick", t0 + 16, 16'h0002, 1'b1, 1'b0, 16'h0000);
      tick_n(5);
      mode_down = 1'b0;
      tick_n(5);
      pause = 1'b0; start = 1'b1;
      tick_n(1);
      start = 1'b0;
      drain();

      // lap in the tick cycle, then lap while paused
      do_clear();
      do_load(16'h0009);
      start_run(1'b0, t0);
      tick_n(3);
      lap = 1'b1;
      lap_q.push_back(16'h0009);
      push_at("lap_t", t0 + 5, 16'h0010, 1'b1, 1'b0, 16'h0009);
      tick_n(1);
      lap = 1'b0;
      drain();
      pause = 1'b1;
      tick_n(1);
      lap = 1'b1;
      lap_q.push_back(16'h0010);
      push_at("lap_p", cyc + 1, 16'h0010, 1'b0, 1'b0, 16'h0010);
      tick_n(1);
      lap = 1'b0; pause = 1'b0;
      drain();
      push_at("lap_clr", cyc + 1, 16'h0000, 1'b0, 1'b0, 16'h0000);
      do_clear();
      lap = 1'b1;
      push_at("lap_idle", cyc + 3, 16'h0000, 1'b0, 1'b0, 16'h0000);
      tick_n(1);
      lap = 1'b0;
      drain();

      // clear beats load; clamp of out-of-range digits
      load = 1'b1; clear = 1'b1; preset = 16'h7A9F;
      push_at("pri", cyc + 1, 16'h0000, 1'b0, 1'b0, 16'h0000);
      tick_n(1);
      clear = 1'b0; load = 1'b0;
      drain();
      push_at("clamp", cyc + 1, 16'h5959, 1'b0, 1'b0, 16'h0000);
      do_load(16'h7A9F);
      drain();

      // load ignored in RUN, then asynchronous reset mid-count
      do_clear();
      do_load(16'h1234);
      start_run(1'b0, t0);
      load = 1'b1; preset = 16'h0000;
      push_at("rl_ign", t0 + 5, 16'h1235, 1'b1, 1'b0, 16'h0000);
      tick_n(1);
      load = 1'b0;
      drain();
      lap = 1'b1;
      lap_q.push_back(16'h1235);
      tick_n(1);
      lap = 1'b0;
      drain();
      #1 rst = 1'b1;
      #1;
      check_eq("arst_time", time_bcd, 16'h0000);
      check_eq("arst_lap", lap_bcd, 16'h0000);
      check_eq("arst_lapv", {15'd0, lap_valid}, 16'h0000);
      check_eq("arst_run", {15'd0, running}, 16'h0000);
      check_eq("arst_done", {15'd0, done}, 16'h0000);
      tick_n(2);
      rst = 1'b0;
      push_at("post_rst", cyc + 2, 16'h0000, 1'b0, 1'b0, 16'h0000);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
